retire_checker: RTL

- Synthesizable consumer of the hart retire interface; sits directly downstream of `hart` in the simulation top and in FPGA bring-up builds.
- Keeps a 32-entry shadow register file rebuilt from retired writes, checks every retire record for architectural consistency, and keeps performance counters.
- Reports halt, timeout, and the first error with its code and PC, so benches and hardware no longer need printf-style trace inspection.

---
 rtl/retire_pkg.sv | 26 ++
 rtl/shadow_regfile.sv | 19 +
 rtl/retire_checker.sv | 109 ++++++++++
 3 files changed

// File: rtl/retire_pkg.sv
// retire_pkg: opcodes, error codes, FSM states and decode helpers for retire_checker
package retire_pkg;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {
    E_NONE, E_PC, E_RS1, E_RS2, E_MEM, E_MASK, E_HALT, E_TIMEOUT
  } err_e;
  typedef enum logic [1:0] {S_RUN, S_HALTED, S_ERROR} state_e;
  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP, STORE, BRANCH};
  endfunction
  function automatic logic legal_mask(input logic [3:0] mask);
    return mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction
endpackage

// File: rtl/shadow_regfile.sv
// shadow_regfile: 32x32 register file, two async read ports, one sync write port, x0 reads 0
module shadow_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [32];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && waddr != 5'd0) regs[waddr] <= wdata;
  assign rdata1 = raddr1 == 5'd0 ? '0 : regs[raddr1];
  assign rdata2 = raddr2 == 5'd0 ? '0 : regs[raddr2];
endmodule

// File: rtl/retire_checker.sv
// retire_checker: checks hart retire records against a shadow regfile, counts perf events, flags halt/timeout/first error
module retire_checker
  import retire_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0,
  parameter int          MAX_CYCLES = 40000,
  parameter int          CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_retire_valid,
  input  logic [31:0]      i_retire_inst,
  input  logic             i_retire_trap,
  input  logic             i_retire_halt,
  input  logic [4:0]       i_retire_rs1_raddr,
  input  logic [4:0]       i_retire_rs2_raddr,
  input  logic [31:0]      i_retire_rs1_rdata,
  input  logic [31:0]      i_retire_rs2_rdata,
  input  logic [4:0]       i_retire_rd_waddr,
  input  logic [31:0]      i_retire_rd_wdata,
  input  logic             i_retire_dmem_ren,
  input  logic             i_retire_dmem_wen,
  input  logic [3:0]       i_retire_dmem_mask,
  input  logic [31:0]      i_retire_pc,
  input  logic [31:0]      i_retire_next_pc,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_loads,
  output logic [CNT_W-1:0] o_stores,
  output logic [CNT_W-1:0] o_traps,
  output logic             o_halted,
  output logic             o_error,
  output logic [2:0]       o_error_code,
  output logic [31:0]      o_error_pc
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CYCLES);
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c);
    return c == CMAX ? c : c + 1'b1;
  endfunction
  state_e      state, state_nx;
  logic [31:0] exp_pc, rs1_sh, rs2_sh;
  logic [6:0]  opc;
  logic [2:0]  rec_err, err;
  logic        run, timeout, unused_ok;
  assign opc       = i_retire_inst[6:0];
  assign unused_ok = ^i_retire_inst[31:7];
  shadow_regfile u_shadow (
    .clk    (i_clk),
    .rst    (i_rst),
    .we     (i_retire_valid && !i_retire_trap),
    .waddr  (i_retire_rd_waddr),
    .wdata  (i_retire_rd_wdata),
    .raddr1 (i_retire_rs1_raddr),
    .raddr2 (i_retire_rs2_raddr),
    .rdata1 (rs1_sh),
    .rdata2 (rs2_sh)
  );
  always_comb begin
    run     = state == S_RUN;
    rec_err = i_retire_pc != exp_pc                                  ? E_PC   :
              uses_rs1(opc) && i_retire_rs1_rdata != rs1_sh          ? E_RS1  :
              uses_rs2(opc) && i_retire_rs2_rdata != rs2_sh          ? E_RS2  :
              i_retire_dmem_ren && i_retire_dmem_wen                 ? E_MEM  :
              (i_retire_dmem_ren || i_retire_dmem_wen) &&
                !legal_mask(i_retire_dmem_mask)                      ? E_MASK :
              state == S_HALTED                                      ? E_HALT : E_NONE;
    // Timeout fires on the edge that brings o_cycles to MAX_CYCLES, so the count freezes there
    timeout = run && o_cycles != MAXC && inc(o_cycles) == MAXC;
    err     = i_retire_valid && state != S_ERROR && rec_err != E_NONE ? rec_err :
              timeout ? E_TIMEOUT : E_NONE;
    state_nx = state;
    if (run && i_retire_valid && i_retire_halt) state_nx = S_HALTED;
    if (err != E_NONE) state_nx = S_ERROR;
  end
  always_ff @(posedge i_clk)
    if (i_rst) state <= S_RUN;
    else state <= state_nx;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      exp_pc       <= RESET_ADDR;
      o_cycles     <= '0;
      o_retired    <= '0;
      o_loads      <= '0;
      o_stores     <= '0;
      o_traps      <= '0;
      o_halted     <= 1'b0;
      o_error      <= 1'b0;
      o_error_code <= '0;
      o_error_pc   <= '0;
    end else begin
      if (i_retire_valid) exp_pc <= i_retire_next_pc;
      if (run) begin
        o_cycles <= inc(o_cycles);
        if (i_retire_valid) begin
          o_retired <= inc(o_retired);
          if (i_retire_dmem_ren) o_loads <= inc(o_loads);
          if (i_retire_dmem_wen) o_stores <= inc(o_stores);
          if (i_retire_trap) o_traps <= inc(o_traps);
        end
      end
      if (run && state_nx == S_HALTED) o_halted <= 1'b1;
      if (!o_error && err != E_NONE) begin
        o_error      <= 1'b1;
        o_error_code <= err;
        o_error_pc   <= i_retire_pc;
      end
    end
endmodule
